// File: rtl/filtered_line_tx.sv
// Framed single-line serial transmitter: start(1), data LSB first, stop(0).
// Every symbol level is held BIT_CYCLES clocks, with optional one-cycle glitch injection.
module filtered_line_tx #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BIT_CYCLES = 8,
  parameter int unsigned GLITCH_POS = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              glitch_en,
  output logic              ready_out,
  output logic              line_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(BIT_CYCLES);
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GLITCH_AT = CNT_W'(GLITCH_POS);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              glitch_q, glitch_d;
  logic              line_q, line_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sym_end_c;
  logic              nominal_c;

  // State register; reset abandons any frame in progress immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      glitch_q <= 1'b0;
      line_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      glitch_q <= glitch_d;
      line_q   <= line_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic; outputs are derived from the next state so they register in step.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    data_d    = data_q;
    glitch_d  = glitch_q;
    done_d    = 1'b0;
    nominal_c = 1'b0;
    sym_end_c = (cnt_q == CNT_LAST);

    unique case (state_q)
      S_IDLE: begin
        if (valid_in && ready_q) begin
          state_d  = S_START;
          cnt_d    = '0;
          bit_d    = '0;
          data_d   = data_in;
          glitch_d = glitch_en;
        end
      end
      S_START: begin
        if (sym_end_c) begin
          state_d = S_DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (sym_end_c) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (sym_end_c) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          bit_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase

    unique case (state_d)
      S_START: nominal_c = 1'b1;
      S_DATA:  nominal_c = data_d[bit_d];
      default: nominal_c = 1'b0;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    // Invert exactly one cycle per symbol when the frame was accepted with glitch_en.
    line_d  = nominal_c ^ (busy_d && glitch_d && (cnt_d == GLITCH_AT));
  end

  assign ready_out = ready_q;
  assign line_out  = line_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/filtered_line_tx.md
Name: filtered_line_tx

Overview:
- Single-line serial transmitter that drives a slow-changing, filter-friendly waveform.
- Each symbol level is held for a fixed number of clock cycles, so a downstream majority/run-length glitch filter passes it cleanly.
- Accepts parallel words over a valid/ready handshake and emits a framed bit sequence: start, data LSB first, stop.
- Optional one-cycle glitch injection per bit period, used as stimulus to prove the receive-side filter rejects short pulses.

Parameters:
- DATA_W, 8, data word width in bits (legal 1..16).
- BIT_CYCLES, 8, clock cycles each symbol level is held (legal 5..255).
- GLITCH_POS, 2, 0-based cycle offset inside each bit period where an injected glitch lands (legal 1..BIT_CYCLES-2).

Ports:
- clock  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-low reset
- data_in  input  DATA_W  word to transmit
- valid_in  input  1  data_in valid
- glitch_en  input  1  inject glitches into this frame; sampled at acceptance
- ready_out  output  1  block can accept a word
- line_out  output  1  serial line, registered
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse when frame completes

Behaviour:
- Reset: asynchronous, active-low on reset; clock is clock. While reset is low:
  - line_out=0, ready_out=1, busy=0, done=0, state=IDLE.
  - Bit and cycle counters cleared; latched data and glitch flag cleared.
  - Any frame in progress is abandoned immediately, with no completion of the stop bit.
- Idle line level is 0. Start bit is 1. Stop bit is 0.
- State machine:
  - IDLE: ready_out=1, line_out=0. A rising edge with valid_in=1 and ready_out=1 is the acceptance edge (E0).
    - At E0: latch data_in and glitch_en; set ready_out=0, busy=1; go to START; line_out=1 (injected glitch applies per the glitch rules below).
  - START: hold 1 for BIT_CYCLES cycles, then go to DATA with bit index 0.
  - DATA: drive data[bit index] for BIT_CYCLES cycles each, LSB first; after bit DATA_W-1, go to STOP.
  - STOP: drive 0 for BIT_CYCLES cycles. At the final edge, E((DATA_W+2)*BIT_CYCLES):
    - go to IDLE; ready_out=1, busy=0; done=1 for exactly one cycle.
- Symbol timing:
  - Cycle counter runs 0..BIT_CYCLES-1 within each symbol and wraps to 0 on symbol advance.
  - Bit index advances only on wrap.
- Glitch injection:
  - Applies only when the latched glitch flag is 1.
  - In every symbol (start, data, stop), line_out is the inverse of the nominal level for exactly the one cycle where the cycle counter equals GLITCH_POS.
  - All other cycles carry the nominal level.
  - glitch_en changes mid-frame have no effect.
- Timing rules:
  - Frame length is exactly (DATA_W+2)*BIT_CYCLES cycles from E0.
  - Earliest next acceptance is the edge after done. This guarantees at least one idle-low cycle between frames.
- valid_in while busy is ignored. data_in and glitch_en may change freely then without affecting the current frame.
- All outputs are registered: no combinational path from inputs to outputs.

Test Plan:
- Reset:
  - Assert reset with clock running → line_out=0, ready_out=1, busy=0, done=0, held for the full reset duration.
- Single frame, no glitch (defaults):
  - Send 0xA5, glitch_en=0.
  - line_out=1 for 8 cycles after E0, then data bits 1,0,1,0,0,1,0,1, each 8 cycles.
  - Then stop 0 for 8 cycles.
  - busy high for exactly 80 cycles; done pulses exactly at E80; ready_out high again at E80.
- Glitch frame:
  - Send 0x00, glitch_en=1.
  - Start bit shows one 0 cycle at offset 2; each data and stop bit shows one 1 cycle at offset 2.
  - A 4-sample majority/run filter on line_out recovers the clean 0x00 frame with no spurious transitions.
- Back-to-back:
  - Hold valid_in=1 with 0x3C, then 0xC3.
  - Second word accepted on the edge after done.
  - Exactly one idle-low cycle between frames; both frames bit-exact.
- Reset mid-frame:
  - Assert reset at cycle 30 of a 0xFF frame → line_out=0 immediately, with no done pulse.
  - After release, send 0x5A → transmitted bit-exact, 80 cycles.
- Busy ignore:
  - Pulse valid_in with 0x11 at cycle 20 of a 0xEE frame → ignored.
  - ready_out stays 0; the 0xEE frame is unaltered; no second frame follows.
